// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, ALU operation codes, datapath mux selects and the decoded instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CMP  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  typedef struct packed {
    logic add;
    logic sub;
    logic slt;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
  } instr_class_t;

endpackage

// File: rtl/mc_controller_instr_class_dec.sv
// Combinational opcode/funct decode into one-hot instruction class flags;
// any encoding that matches no class is reported as illegal.
module instr_class_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls.add = 1'b1;
          FN_SUB:  cls.sub = 1'b1;
          FN_SLT:  cls.slt = 1'b1;
          FN_JR:   cls.jr  = 1'b1;
          default: ;
        endcase
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_BNE:  cls.bne = 1'b1;
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      default: ;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back over
// a shared request/ready memory port and counts retired instructions.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int BOOT_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic             ext_op,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int                BOOT_W    = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

  state_e             state_q, state_d;
  logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  instr_class_t       cls;
  logic               dec_illegal;
  logic               is_rtype_alu;

  instr_class_dec u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign is_rtype_alu = cls.add | cls.sub | cls.slt;
  assign instr_cnt    = instr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_ctrl   = 4'b0000;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_FETCH;
        else                         boot_cnt_d = boot_cnt_q + 1'b1;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.j || cls.jal) begin
          // PC already holds PC+4, which jal links into $31
          pc_we   = 1'b1;
          pc_sel  = PC_JUMP;
          reg_we  = cls.jal;
          reg_dst = cls.jal ? RD_RA : RD_RT;
          wd_sel  = cls.jal ? WD_PC : WD_ALU;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          pc_sel  = PC_RS;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls.beq || cls.bne) begin
          alu_ctrl = ALU_CMP;
          ext_op   = 1'b1;
          pc_sel   = PC_BRANCH;
          pc_we    = cls.beq ? zero : !zero;
          retire   = 1'b1;
          state_d  = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          alu_ctrl = ALU_ADD;
          alu_src  = 1'b1;
          ext_op   = 1'b1;
          state_d  = ST_MEM;
        end else begin
          alu_src = cls.ori | cls.lui;
          if (cls.add)      alu_ctrl = ALU_ADD;
          else if (cls.sub) alu_ctrl = ALU_SUB;
          else if (cls.slt) alu_ctrl = ALU_SLT;
          else if (cls.ori) alu_ctrl = ALU_OR;
          else if (cls.lui) alu_ctrl = ALU_LUI;
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = cls.sw;
        if (mem_ready) begin
          retire  = cls.sw;
          state_d = cls.sw ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        reg_dst = is_rtype_alu ? RD_RD : RD_RT;
        wd_sel  = cls.lw ? WD_MDR : WD_ALU;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase

    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a table of instructions with hand-computed cycle
// counts and control settings, plus boot and reset-during-stalled-store sequences.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src, ext_op, illegal, retire;
  logic [1:0]  pc_sel, reg_dst, wd_sel;
  logic [3:0]  alu_ctrl;
  logic [31:0] instr_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  mc_controller #(.CNT_W(32), .BOOT_CYC(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_src   (alu_src),
    .ext_op    (ext_op),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .retire    (retire),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  wire [19:0] outs_vec = {mem_req, mem_we, iord, ir_we, pc_we, pc_sel, reg_we, reg_dst,
                          wd_sel, alu_src, ext_op, alu_ctrl, illegal, retire};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         stalls;
    int         cyc;
    int         irw;
    int         regw;
    logic [1:0] dst;
    logic [1:0] wd;
    logic       pcwe;
    logic [1:0] pcsel;
    int         memw;
    int         ill;
    logic [3:0] alu;
    logic       src;
    logic       ext;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Releases reset on a falling edge and expects the first fetch request two edges later.
  task automatic release_and_boot(input string tag);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_req_c1"}, int'(mem_req), 0);
    @(posedge clk);
    #1 chk({tag, "_req_c2"}, int'(mem_req), 1);
    chk({tag, "_cnt"}, int'(instr_cnt), 0);
    @(posedge clk);
  endtask

  // Entered just after an edge with the FSM in FETCH; returns just after the edge back into FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, irw, regw, memw, ill, stalls;
    logic [1:0] dst, wd, pcsel;
    logic       pcwe, src, ext;
    logic [3:0] alu;
    bit         done;
    string      t;
    cyc = 0; irw = 0; regw = 0; memw = 0; ill = 0; stalls = v.stalls;
    dst = '0; wd = '0; pcsel = '0; pcwe = 1'b0; src = 1'b0; ext = 1'b0; alu = '0; done = 1'b0;
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req && iord && stalls > 0) begin
        mem_ready = 1'b0;
        stalls--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (ir_we) irw++;
      if (reg_we) begin
        regw++;
        dst = reg_dst;
        wd  = wd_sel;
      end
      if (mem_we) memw++;
      if (illegal) ill++;
      if (cyc == 2) begin
        alu = alu_ctrl;
        src = alu_src;
        ext = ext_op;
      end
      pcwe  = pc_we;
      pcsel = pc_sel;
      cyc++;
      if (retire || illegal) done = 1'b1;
      @(posedge clk);
    end
    #1;
    if (v.ill == 0) exp_cnt++;
    t = $sformatf("v%0d", idx);
    chk({t, "_cycles"}, cyc, v.cyc);
    chk({t, "_ir_we"}, irw, v.irw);
    chk({t, "_reg_we"}, regw, v.regw);
    chk({t, "_reg_dst"}, int'(dst), int'(v.dst));
    chk({t, "_wd_sel"}, int'(wd), int'(v.wd));
    chk({t, "_pc_we_last"}, int'(pcwe), int'(v.pcwe));
    chk({t, "_pc_sel_last"}, int'(pcsel), int'(v.pcsel));
    chk({t, "_mem_we"}, memw, v.memw);
    chk({t, "_illegal"}, ill, v.ill);
    chk({t, "_alu_ctrl"}, int'(alu), int'(v.alu));
    chk({t, "_alu_src"}, int'(src), int'(v.src));
    chk({t, "_ext_op"}, int'(ext), int'(v.ext));
    chk({t, "_instr_cnt"}, int'(instr_cnt), exp_cnt);
  endtask

  initial begin
    //               op        fn        z     st cyc irw rw dst    wd      pcwe  pcsel      mw il alu      src   ext
    vecs[0]  = '{OP_RTYPE, FN_ADD, 1'b0, 0, 4, 1, 1, RD_RD, WD_ALU, 1'b0, PC_PLUS4,  0, 0, ALU_ADD, 1'b0, 1'b0};
    vecs[1]  = '{OP_ORI,   6'd0,   1'b0, 0, 4, 1, 1, RD_RT, WD_ALU, 1'b0, PC_PLUS4,  0, 0, ALU_OR,  1'b1, 1'b0};
    vecs[2]  = '{OP_LUI,   6'd0,   1'b0, 0, 4, 1, 1, RD_RT, WD_ALU, 1'b0, PC_PLUS4,  0, 0, ALU_LUI, 1'b1, 1'b0};
    vecs[3]  = '{OP_SW,    6'd0,   1'b0, 0, 4, 1, 0, RD_RT, WD_ALU, 1'b0, PC_PLUS4,  1, 0, ALU_ADD, 1'b1, 1'b1};
    vecs[4]  = '{OP_LW,    6'd0,   1'b0, 0, 5, 1, 1, RD_RT, WD_MDR, 1'b0, PC_PLUS4,  0, 0, ALU_ADD, 1'b1, 1'b1};
    vecs[5]  = '{OP_RTYPE, FN_SUB, 1'b0, 0, 4, 1, 1, RD_RD, WD_ALU, 1'b0, PC_PLUS4,  0, 0, ALU_SUB, 1'b0, 1'b0};
    vecs[6]  = '{OP_RTYPE, FN_SLT, 1'b0, 0, 4, 1, 1, RD_RD, WD_ALU, 1'b0, PC_PLUS4,  0, 0, ALU_SLT, 1'b0, 1'b0};
    vecs[7]  = '{OP_BEQ,   6'd0,   1'b1, 0, 3, 1, 0, RD_RT, WD_ALU, 1'b1, PC_BRANCH, 0, 0, ALU_CMP, 1'b0, 1'b1};
    vecs[8]  = '{OP_BNE,   6'd0,   1'b1, 0, 3, 1, 0, RD_RT, WD_ALU, 1'b0, PC_BRANCH, 0, 0, ALU_CMP, 1'b0, 1'b1};
    vecs[9]  = '{OP_BNE,   6'd0,   1'b0, 0, 3, 1, 0, RD_RT, WD_ALU, 1'b1, PC_BRANCH, 0, 0, ALU_CMP, 1'b0, 1'b1};
    vecs[10] = '{OP_BEQ,   6'd0,   1'b0, 0, 3, 1, 0, RD_RT, WD_ALU, 1'b0, PC_BRANCH, 0, 0, ALU_CMP, 1'b0, 1'b1};
    vecs[11] = '{OP_J,     6'd0,   1'b0, 0, 2, 1, 0, RD_RT, WD_ALU, 1'b1, PC_JUMP,   0, 0, 4'd0,    1'b0, 1'b0};
    vecs[12] = '{OP_JAL,   6'd0,   1'b0, 0, 2, 1, 1, RD_RA, WD_PC,  1'b1, PC_JUMP,   0, 0, 4'd0,    1'b0, 1'b0};
    vecs[13] = '{OP_RTYPE, FN_JR,  1'b0, 0, 2, 1, 0, RD_RT, WD_ALU, 1'b1, PC_RS,     0, 0, 4'd0,    1'b0, 1'b0};
    vecs[14] = '{6'b111111, 6'd0,  1'b0, 0, 2, 1, 0, RD_RT, WD_ALU, 1'b0, PC_PLUS4,  0, 1, 4'd0,    1'b0, 1'b0};
    vecs[15] = '{OP_RTYPE, 6'b000001, 1'b0, 0, 2, 1, 0, RD_RT, WD_ALU, 1'b0, PC_PLUS4, 0, 1, 4'd0, 1'b0, 1'b0};
    vecs[16] = '{OP_LW,    6'd0,   1'b0, 3, 8, 1, 1, RD_RT, WD_MDR, 1'b0, PC_PLUS4,  0, 0, ALU_ADD, 1'b1, 1'b1};

    // Reset held with inputs that would otherwise request activity
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_LW;
    repeat (2) @(negedge clk);
    #1 chk("rst_outs", int'(outs_vec), 0);
    chk("rst_cnt", int'(instr_cnt), 0);
    release_and_boot("boot");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Store stalled in MEM, then reset asserted asynchronously mid-access
    opcode    = OP_SW;
    funct     = 6'd0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("stall_mem_req", int'(mem_req), 1);
    chk("stall_mem_we", int'(mem_we), 1);
    chk("stall_iord", int'(iord), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midrst_mem_req", int'(mem_req), 0);
    chk("midrst_mem_we", int'(mem_we), 0);
    chk("midrst_outs", int'(outs_vec), 0);
    chk("midrst_cnt", int'(instr_cnt), 0);
    release_and_boot("reboot");

    exp_cnt = 0;
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
